video_out_adapter: RTL and testbench



---
 rtl/video_out_adapter_pkg.sv | 46 ++++
 rtl/video_out_adapter_color_expand.sv | 14 +
 rtl/video_out_adapter.sv | 171 +++++++++++++++++
 tb/tb_video_out_adapter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_out_adapter_pkg.sv
// Shared scan-mode encodings and colour helpers for the video output adapter.
package video_pkg;

  localparam int MAX_W = 12;

  typedef enum logic [1:0] {
    SCAN_OFF = 2'b00,
    SCAN_25  = 2'b01,
    SCAN_50  = 2'b10,
    SCAN_75  = 2'b11
  } scan_e;

  // Fills outW bits MSB-first by cycling through the inW source bits, so the
  // low DAC bits repeat the colour's MSBs instead of sitting at zero.
  function automatic logic [MAX_W-1:0] replicate(input logic [MAX_W-1:0] value,
                                                 input int inW,
                                                 input int outW);
    logic [MAX_W-1:0] result;
    logic [3:0]       src;
    logic [3:0]       dst;
    result = '0;
    src    = '0;
    dst    = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < outW) begin
        dst         = 4'(outW - 1 - i);
        src         = 4'(inW - 1 - (i % inW));
        result[dst] = value[src];
      end
    end
    return result;
  endfunction

  function automatic logic [MAX_W-1:0] dim(input logic [MAX_W-1:0] value,
                                           input scan_e mode);
    logic [MAX_W-1:0] result;
    case (mode)
      SCAN_25: result = value - (value >> 2);
      SCAN_50: result = value >> 1;
      SCAN_75: result = value >> 2;
      default: result = value;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/video_out_adapter_color_expand.sv
// Combinational per-channel width expansion by MSB replication.
module color_expand
  import video_pkg::*;
#(
  parameter int IN_W  = 6,
  parameter int OUT_W = 8
) (
  input  logic [IN_W-1:0]  i_value,
  output logic [OUT_W-1:0] o_value
);

  assign o_value = OUT_W'(replicate(MAX_W'(i_value), IN_W, OUT_W));

endmodule

// File: rtl/video_out_adapter.sv
// Registered VGA output stage: colour expansion, scanline dimming,
// frame-synchronous mode latching and sync polarity inversion.
module video_out_adapter
  import video_pkg::*;
#(
  parameter int IN_W     = 6,
  parameter int OUT_W    = 8,
  parameter int DELAY    = 2,
  parameter bit SYNC_ACT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_ce,
  input  logic [IN_W-1:0]  r_in,
  input  logic [IN_W-1:0]  g_in,
  input  logic [IN_W-1:0]  b_in,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic             blank_in,
  input  logic [1:0]       scan_mode,
  input  logic             sync_inv,
  output logic [OUT_W-1:0] vga_r,
  output logic [OUT_W-1:0] vga_g,
  output logic [OUT_W-1:0] vga_b,
  output logic             vga_hs,
  output logic             vga_vs
);

  if (IN_W < 1 || IN_W > OUT_W || OUT_W > MAX_W || DELAY < 2 || DELAY > 4) begin : g_badParams
    $error("video_out_adapter: illegal IN_W/OUT_W/DELAY combination");
  end

  logic             r_hsPrev;
  logic             r_vsPrev;
  logic             r_parity;
  scan_e            r_mode;
  logic             r_inv;

  logic             w_hsEdge;
  logic             w_vsEdge;
  logic             w_parNext;
  scan_e            w_modeNext;
  logic             w_invNext;

  logic [IN_W-1:0]  w_rSrc;
  logic [IN_W-1:0]  w_gSrc;
  logic [IN_W-1:0]  w_bSrc;
  logic [OUT_W-1:0] w_rExp;
  logic [OUT_W-1:0] w_gExp;
  logic [OUT_W-1:0] w_bExp;

  logic [OUT_W-1:0] r_s1R;
  logic [OUT_W-1:0] r_s1G;
  logic [OUT_W-1:0] r_s1B;
  logic             r_s1Par;
  scan_e            r_s1Mode;
  scan_e            w_s1DimMode;

  logic [OUT_W-1:0] r_pipeR [2:DELAY];
  logic [OUT_W-1:0] r_pipeG [2:DELAY];
  logic [OUT_W-1:0] r_pipeB [2:DELAY];
  logic             r_hsPipe [1:DELAY-1];
  logic             r_vsPipe [1:DELAY-1];

  assign w_hsEdge = pix_ce && (hs_in == SYNC_ACT) && (r_hsPrev != SYNC_ACT);
  assign w_vsEdge = pix_ce && (vs_in == SYNC_ACT) && (r_vsPrev != SYNC_ACT);

  // Next-state of parity and effective mode; the pixel sampled on an edge
  // strobe already sees the new values, and vs wins over a coincident hs.
  always_comb begin
    w_parNext  = r_parity;
    w_modeNext = r_mode;
    w_invNext  = r_inv;
    if (w_vsEdge) begin
      w_parNext  = 1'b0;
      w_modeNext = scan_e'(scan_mode);
      w_invNext  = sync_inv;
    end else if (w_hsEdge) begin
      w_parNext = ~r_parity;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsPrev <= ~SYNC_ACT;
      r_vsPrev <= ~SYNC_ACT;
      r_parity <= 1'b0;
      r_mode   <= SCAN_OFF;
      r_inv    <= 1'b0;
    end else if (pix_ce) begin
      r_hsPrev <= hs_in;
      r_vsPrev <= vs_in;
      r_parity <= w_parNext;
      r_mode   <= w_modeNext;
      r_inv    <= w_invNext;
    end
  end

  assign w_rSrc = blank_in ? '0 : r_in;
  assign w_gSrc = blank_in ? '0 : g_in;
  assign w_bSrc = blank_in ? '0 : b_in;

  color_expand #(.IN_W(IN_W), .OUT_W(OUT_W)) u_expandR (.i_value(w_rSrc), .o_value(w_rExp));
  color_expand #(.IN_W(IN_W), .OUT_W(OUT_W)) u_expandG (.i_value(w_gSrc), .o_value(w_gExp));
  color_expand #(.IN_W(IN_W), .OUT_W(OUT_W)) u_expandB (.i_value(w_bSrc), .o_value(w_bExp));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1R    <= '0;
      r_s1G    <= '0;
      r_s1B    <= '0;
      r_s1Par  <= 1'b0;
      r_s1Mode <= SCAN_OFF;
    end else if (pix_ce) begin
      r_s1R    <= w_rExp;
      r_s1G    <= w_gExp;
      r_s1B    <= w_bExp;
      r_s1Par  <= w_parNext;
      r_s1Mode <= w_modeNext;
    end
  end

  assign w_s1DimMode = r_s1Par ? r_s1Mode : SCAN_OFF;

  // Stage 2 applies scanline dimming; later stages only add latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 2; i <= DELAY; i++) begin
        r_pipeR[i] <= '0;
        r_pipeG[i] <= '0;
        r_pipeB[i] <= '0;
      end
    end else if (pix_ce) begin
      r_pipeR[2] <= OUT_W'(dim(MAX_W'(r_s1R), w_s1DimMode));
      r_pipeG[2] <= OUT_W'(dim(MAX_W'(r_s1G), w_s1DimMode));
      r_pipeB[2] <= OUT_W'(dim(MAX_W'(r_s1B), w_s1DimMode));
      for (int i = 3; i <= DELAY; i++) begin
        r_pipeR[i] <= r_pipeR[i-1];
        r_pipeG[i] <= r_pipeG[i-1];
        r_pipeB[i] <= r_pipeB[i-1];
      end
    end
  end

  assign vga_r = r_pipeR[DELAY];
  assign vga_g = r_pipeG[DELAY];
  assign vga_b = r_pipeB[DELAY];

  // Inversion is folded into the final sync register so a newly latched
  // invert shows on the pins right after the vs edge that captured it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= DELAY-1; i++) begin
        r_hsPipe[i] <= ~SYNC_ACT;
        r_vsPipe[i] <= ~SYNC_ACT;
      end
      vga_hs <= ~SYNC_ACT;
      vga_vs <= ~SYNC_ACT;
    end else if (pix_ce) begin
      r_hsPipe[1] <= hs_in;
      r_vsPipe[1] <= vs_in;
      for (int i = 2; i <= DELAY-1; i++) begin
        r_hsPipe[i] <= r_hsPipe[i-1];
        r_vsPipe[i] <= r_vsPipe[i-1];
      end
      vga_hs <= r_hsPipe[DELAY-1] ^ w_invNext;
      vga_vs <= r_vsPipe[DELAY-1] ^ w_invNext;
    end
  end

endmodule

// File: tb/tb_video_out_adapter.sv
// Self-checking bench for video_out_adapter: vector table, corner-case
// sequences and a randomized run against a queue-based reference model.
module tb_video_out_adapter;

  localparam int IN_W  = 6;
  localparam int OUT_W = 8;
  localparam int DELAY = 2;
  localparam bit ACT   = 1'b0;

  logic             clk;
  logic             rst_n;
  logic             pix_ce;
  logic [IN_W-1:0]  r_in;
  logic [IN_W-1:0]  g_in;
  logic [IN_W-1:0]  b_in;
  logic             hs_in;
  logic             vs_in;
  logic             blank_in;
  logic [1:0]       scan_mode;
  logic             sync_inv;
  logic [OUT_W-1:0] vga_r;
  logic [OUT_W-1:0] vga_g;
  logic [OUT_W-1:0] vga_b;
  logic             vga_hs;
  logic             vga_vs;

  int checks   = 0;
  int failures = 0;

  video_out_adapter #(
    .IN_W(IN_W), .OUT_W(OUT_W), .DELAY(DELAY), .SYNC_ACT(ACT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hs_in(hs_in), .vs_in(vs_in), .blank_in(blank_in),
    .scan_mode(scan_mode), .sync_inv(sync_inv),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model: pixels travel through a queue DELAY-1 entries deep
  typedef struct {
    logic [OUT_W-1:0] r;
    logic [OUT_W-1:0] g;
    logic [OUT_W-1:0] b;
    logic             hs;
    logic             vs;
  } pix_t;

  pix_t q[$];
  pix_t mExp;
  logic mHsPrev, mVsPrev, mPar, mInv;
  int   mMode;

  function automatic int expandModel(int v);
    int acc  = v;
    int bits = IN_W;
    while (bits < OUT_W) begin
      acc  = (acc << IN_W) | v;
      bits = bits + IN_W;
    end
    return acc >> (bits - OUT_W);
  endfunction

  function automatic int dimModel(int v, int mode);
    case (mode)
      1:       return v - v / 4;
      2:       return v / 2;
      3:       return v / 4;
      default: return v;
    endcase
  endfunction

  function automatic logic [OUT_W-1:0] pixelModel(logic [IN_W-1:0] c);
    int v;
    v = blank_in ? 0 : expandModel(int'(c));
    if (mPar) v = dimModel(v, mMode);
    return OUT_W'(v);
  endfunction

  task automatic modelReset();
    pix_t idle;
    idle.r = '0; idle.g = '0; idle.b = '0; idle.hs = ~ACT; idle.vs = ~ACT;
    q.delete();
    for (int i = 0; i < DELAY - 1; i++) q.push_back(idle);
    mExp    = idle;
    mHsPrev = ~ACT;
    mVsPrev = ~ACT;
    mPar    = 1'b0;
    mInv    = 1'b0;
    mMode   = 0;
  endtask

  task automatic modelStep();
    pix_t p;
    logic hsE, vsE;
    hsE     = (hs_in == ACT) && (mHsPrev != ACT);
    vsE     = (vs_in == ACT) && (mVsPrev != ACT);
    mHsPrev = hs_in;
    mVsPrev = vs_in;
    if (vsE) begin
      mPar  = 1'b0;
      mMode = int'(scan_mode);
      mInv  = sync_inv;
    end else if (hsE) begin
      mPar = ~mPar;
    end
    p.r  = pixelModel(r_in);
    p.g  = pixelModel(g_in);
    p.b  = pixelModel(b_in);
    p.hs = hs_in;
    p.vs = vs_in;
    q.push_back(p);
    mExp = q.pop_front();
  endtask

  task automatic checkOutput(input string name);
    logic expHs, expVs;
    expHs  = mExp.hs ^ mInv;
    expVs  = mExp.vs ^ mInv;
    checks = checks + 1;
    if (vga_r !== mExp.r || vga_g !== mExp.g || vga_b !== mExp.b ||
        vga_hs !== expHs || vga_vs !== expVs) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got rgb=%h/%h/%h hs=%b vs=%b, expected rgb=%h/%h/%h hs=%b vs=%b",
               name, vga_r, vga_g, vga_b, vga_hs, vga_vs,
               mExp.r, mExp.g, mExp.b, expHs, expVs);
    end
  endtask

  task automatic checkConst(input string name, input logic [OUT_W-1:0] actual,
                            input logic [OUT_W-1:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic tick(input string name);
    @(posedge clk);
    if (rst_n && pix_ce) modelStep();
    #1;
    checkOutput(name);
  endtask

  task automatic applyStimulus(input logic [IN_W-1:0] r, input logic [IN_W-1:0] g,
                               input logic [IN_W-1:0] b, input logic blank);
    r_in     = r;
    g_in     = g;
    b_in     = b;
    blank_in = blank;
  endtask

  task automatic hsPulse();
    hs_in = ACT;  tick("hsPulse");
    hs_in = ~ACT; tick("hsPulse");
  endtask

  task automatic vsPulse();
    vs_in = ACT;  tick("vsPulse");
    vs_in = ~ACT; tick("vsPulse");
  endtask

  task automatic scanTest(input logic [1:0] mode, input logic [OUT_W-1:0] expOdd);
    scan_mode = mode;
    vsPulse();
    tick("scanEven"); tick("scanEven");
    checkConst("scanEvenLine", vga_r, 8'hFF);
    hsPulse();
    tick("scanOdd"); tick("scanOdd");
    checkConst("scanOddLine", vga_r, expOdd);
  endtask

  typedef struct {
    logic [IN_W-1:0]  r;
    logic             blank;
    logic [OUT_W-1:0] expR;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{r: 6'h3F, blank: 1'b0, expR: 8'hFF};
    vecs[1] = '{r: 6'h20, blank: 1'b0, expR: 8'h82};
    vecs[2] = '{r: 6'h15, blank: 1'b0, expR: 8'h55};
    vecs[3] = '{r: 6'h00, blank: 1'b0, expR: 8'h00};
    vecs[4] = '{r: 6'h3F, blank: 1'b1, expR: 8'h00};
    vecs[5] = '{r: 6'h2A, blank: 1'b0, expR: 8'hAA};

    rst_n = 1'b0; pix_ce = 1'b1;
    applyStimulus('0, '0, '0, 1'b0);
    hs_in = ~ACT; vs_in = ~ACT; scan_mode = 2'b00; sync_inv = 1'b0;
    modelReset();
    #12;
    checkOutput("resetState");
    checkConst("resetHs", {7'b0, vga_hs}, {7'b0, ~ACT});
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].r, vecs[i].r, vecs[i].r, vecs[i].blank);
      tick("expandLatency");
      tick("expand");
      checkConst("expandR", vga_r, vecs[i].expR);
      checkConst("expandB", vga_b, vecs[i].expR);
    end

    applyStimulus(6'h3F, 6'h3F, 6'h3F, 1'b1);
    hs_in = ACT;
    tick("blank"); tick("blank");
    checkConst("blankR", vga_r, 8'h00);
    checkConst("blankHs", {7'b0, vga_hs}, {7'b0, ACT});
    hs_in = ~ACT;
    applyStimulus(6'h3F, 6'h3F, 6'h3F, 1'b0);
    tick("blankEnd"); tick("blankEnd");

    for (int i = 0; i < 24; i++) begin
      pix_ce = (i % 4 == 3);
      if (i % 4 == 0)
        applyStimulus(IN_W'($urandom), IN_W'($urandom), IN_W'($urandom), 1'b0);
      tick("sparseStrobe");
    end
    pix_ce = 1'b1;

    applyStimulus(6'h3F, 6'h3F, 6'h3F, 1'b0);
    scanTest(2'b10, 8'h7F);
    scanTest(2'b01, 8'hC0);
    scanTest(2'b11, 8'h3F);
    hs_in = ACT; vs_in = ACT;
    tick("simulEdge");
    hs_in = ~ACT; vs_in = ~ACT;
    tick("simulEdge"); tick("simulEdge"); tick("simulEdge");
    checkConst("simulEdgeParity", vga_r, 8'hFF);

    scan_mode = 2'b00; sync_inv = 1'b0;
    vsPulse();
    hsPulse();
    tick("midLine"); tick("midLine");
    scan_mode = 2'b10; sync_inv = 1'b1;
    tick("midLine"); tick("midLine"); tick("midLine");
    checkConst("midNoDim", vga_r, 8'hFF);
    checkConst("midNoInv", {7'b0, vga_hs}, {7'b0, ~ACT});
    hsPulse();
    hsPulse();
    tick("midLine"); tick("midLine");
    checkConst("midStillNoDim", vga_r, 8'hFF);
    vs_in = ACT;
    tick("midVsEdge");
    checkConst("midInvHs", {7'b0, vga_hs}, {7'b0, ACT});
    checkConst("midInvVs", {7'b0, vga_vs}, {7'b0, ACT});
    vs_in = ~ACT;
    tick("midVsActive");
    checkConst("midInvVsActive", {7'b0, vga_vs}, {7'b0, ~ACT});
    hsPulse();
    tick("midDim"); tick("midDim");
    checkConst("midDimOdd", vga_r, 8'h7F);

    rst_n = 1'b0;
    #1;
    checkConst("rstMidR", vga_r, 8'h00);
    checkConst("rstMidHs", {7'b0, vga_hs}, {7'b0, ~ACT});
    checkConst("rstMidVs", {7'b0, vga_vs}, {7'b0, ~ACT});
    modelReset();
    tick("inReset");
    rst_n = 1'b1;
    tick("afterReset"); tick("afterReset");
    checkConst("rstTrack", vga_r, 8'hFF);
    hsPulse();
    tick("rstModeOff"); tick("rstModeOff");
    checkConst("rstModeOffR", vga_r, 8'hFF);
    checkConst("rstInvOff", {7'b0, vga_hs}, {7'b0, ~ACT});

    for (int i = 0; i < 600; i++) begin
      pix_ce    = ($urandom_range(0, 3) != 0);
      applyStimulus(IN_W'($urandom), IN_W'($urandom), IN_W'($urandom),
                    ($urandom_range(0, 7) == 0));
      hs_in     = ($urandom_range(0, 5) == 0) ? ACT : ~ACT;
      vs_in     = ($urandom_range(0, 29) == 0) ? ACT : ~ACT;
      scan_mode = 2'($urandom);
      sync_inv  = 1'($urandom);
      tick("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
